cell_expand: RTL and testbench

//  Inverse of the per-cell minimum reducer. Accepts one reduced RGB value per cell
//  (LENGTH+1 pixels) and replays it once per pixel strobe, LENGTH+1 times, so that

---
 rtl/cell_expand_pkg.sv | 11 +
 rtl/cell_fifo.sv | 54 +++++
 rtl/cell_expand.sv | 81 ++++++++
 tb/tb_cell_expand.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_expand_pkg.sv
// Shared definitions for the cell expander: pixel width, default cell
// length and the replay counter width.
package cell_expand_pkg;

  localparam int unsigned PIX_W    = 24;
  localparam int unsigned CELL_LEN = 23;
  localparam int unsigned CNT_W    = 8;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/cell_fifo.sv
// Cell-value FIFO: DEPTH x PIX_W entries, negedge clocked, async active-low
// reset. head is the entry at the read pointer; there is no bypass from
// the write port, so a pushed value is only visible after its write edge.
module cell_fifo
  import cell_expand_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clkn,
  input  logic             resetn,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  output logic [PIX_W-1:0] head,
  output logic             full,
  output logic             empty
);

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/cell_expand.sv
// Cell expander: replays each reduced cell value LENGTH+1 times, once per
// pixel strobe, with sticky overflow/underflow flags.
module cell_expand
  import cell_expand_pkg::*;
#(
  parameter int unsigned LENGTH = CELL_LEN,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic             clkn,
  input  logic             resetn,
  input  logic             valid_min_RGB,
  input  logic [PIX_W-1:0] min_RGB,
  input  logic             valid_pix,
  input  logic             clr_err,
  output logic             valid_pix_RGB,
  output logic [PIX_W-1:0] pix_RGB,
  output logic             fifo_full,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] count;
  logic             last_pix;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             udf_set;
  logic             empty;
  pix_t             head;

  assign last_pix = (count == CNT_W'(LENGTH));
  assign pop      = valid_pix & ~empty & last_pix;
  // A push into a full FIFO is still accepted when the last pixel of the
  // head cell frees a slot on the same edge.
  assign push     = valid_min_RGB & (~fifo_full | pop);
  assign ovf_set  = valid_min_RGB & fifo_full & ~pop;
  assign udf_set  = valid_pix & empty;

  cell_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clkn   (clkn),
    .resetn (resetn),
    .push   (push),
    .din    (min_RGB),
    .pop    (pop),
    .head   (head),
    .full   (fifo_full),
    .empty  (empty)
  );

  // Replay counter and registered pixel output.
  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      count         <= '0;
      pix_RGB       <= '0;
      valid_pix_RGB <= 1'b0;
    end else if (valid_pix && !empty) begin
      pix_RGB       <= head;
      valid_pix_RGB <= 1'b1;
      count         <= last_pix ? '0 : count + 1'b1;
    end else begin
      pix_RGB       <= '0;
      valid_pix_RGB <= 1'b0;
    end
  end

  // Sticky error flags; a new error outranks a same-cycle clear.
  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | udf_set;
    end
  end

endmodule

// File: tb/tb_cell_expand.sv
// Testbench for cell_expand: randomized stimulus against a queue-based
// reference model of the cell replay behaviour.
module tb_cell_expand;

  localparam int LEN   = 23;
  localparam int DEPTH = 4;

  logic        clkn = 1'b1;
  logic        resetn;
  logic        valid_min_RGB;
  logic [23:0] min_RGB;
  logic        valid_pix;
  logic        clr_err;
  logic        valid_pix_RGB;
  logic [23:0] pix_RGB;
  logic        fifo_full;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [23:0] q[$];
  int          m_cnt;
  logic        m_v;
  logic [23:0] m_pix;
  logic        m_ovf;
  logic        m_udf;

  logic [27:0] obs;
  logic [27:0] expv;
  assign obs  = {valid_pix_RGB, pix_RGB, fifo_full, overflow, underflow};
  assign expv = {m_v, m_pix, (q.size() == DEPTH), m_ovf, m_udf};

  always #5 clkn = ~clkn;

  cell_expand #(.LENGTH(LEN), .DEPTH(DEPTH), .AW(2)) dut (
    .clkn          (clkn),
    .resetn        (resetn),
    .valid_min_RGB (valid_min_RGB),
    .min_RGB       (min_RGB),
    .valid_pix     (valid_pix),
    .clr_err       (clr_err),
    .valid_pix_RGB (valid_pix_RGB),
    .pix_RGB       (pix_RGB),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_v = 0; m_pix = '0; m_ovf = 0; m_udf = 0;
  endtask

  // Drive one cycle of inputs (called 1 time unit after a negedge), advance
  // model and DUT through the next negedge, return 1 unit after it.
  task automatic step(input logic vm, input logic [23:0] d, input logic vp, input logic cl);
    int  size0;
    bit  popping;
    bit  eo;
    bit  eu;
    valid_min_RGB = vm; min_RGB = d; valid_pix = vp; clr_err = cl;
    @(negedge clkn);
    size0   = q.size();
    popping = 0;
    eo      = 0;
    eu      = vp && (size0 == 0);
    if (vp && size0 > 0) begin
      m_v   = 1;
      m_pix = q[0];
      if (m_cnt == LEN) begin
        m_cnt   = 0;
        popping = 1;
        void'(q.pop_front());
      end else begin
        m_cnt++;
      end
    end else begin
      m_v   = 0;
      m_pix = '0;
    end
    if (vm) begin
      if (size0 < DEPTH || popping) q.push_back(d);
      else eo = 1;
    end
    m_ovf = (m_ovf && !cl) || eo;
    m_udf = (m_udf && !cl) || eu;
    #1;
    valid_min_RGB = 0; valid_pix = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    resetn = 0; valid_min_RGB = 0; min_RGB = '0; valid_pix = 0; clr_err = 0;
    model_reset();
    repeat (2) @(negedge clkn);
    #1;
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL reset: got %h want %h", obs, expv);
    end
    resetn = 1;
  endtask

  task automatic test_single_cell();
    step(1, 24'h102030, 0, 0);
    for (int i = 0; i < 25; i++) begin
      step(0, '0, 1, 0);   // 25th pixel finds the FIFO empty
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL single_cell px%0d: got %h want %h", i, obs, expv);
      end
    end
    step(0, '0, 0, 1);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL single_cell clr: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_gaps();
    int px = 0;
    int guard = 0;
    step(1, 24'h0A0B0C, 0, 0);
    step(1, 24'hFFFFFF, 0, 0);
    while (px < 48 && guard < 1000) begin
      bit vp = ($urandom_range(0, 2) != 0);
      step(0, '0, vp, 0);
      if (vp) px++;
      guard++;
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL gaps cyc%0d: got %h want %h", guard, obs, expv);
      end
    end
  endtask

  task automatic test_underflow();
    step(0, '0, 1, 0);
    n_checks++;
    if (obs !== expv || underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow set: got %h want %h", obs, expv);
    end
    step(1, 24'h5A5A5A, 0, 0);
    for (int i = 0; i < 25; i++) begin
      step(0, '0, 1, (i == 24));  // clear coincides with new underflow: stays 1
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL underflow replay px%0d: got %h want %h", i, obs, expv);
      end
    end
    step(0, '0, 0, 1);
    n_checks++;
    if (obs !== expv || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow clr: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) step(1, 24'($urandom), 0, 0);
    n_checks++;
    if (obs !== expv || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow set: got %h want %h", obs, expv);
    end
    step(0, '0, 0, 1);
    for (int i = 0; i < LEN + 1; i++) begin
      step((i == LEN), 24'hC0FFEE, 1, 0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL overflow pop_push px%0d: got %h want %h", i, obs, expv);
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow last_pix_push: got ovf=%b full=%b want ovf=0 full=1", overflow, fifo_full);
    end
    for (int i = 0; i < DEPTH * (LEN + 1); i++) begin
      step(0, '0, 1, 0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL overflow drain px%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midcell();
    step(0, '0, 0, 1);
    step(1, 24'h123456, 0, 0);
    step(1, 24'h654321, 0, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
    resetn = 0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL reset_midcell async: got %h want %h", obs, expv);
    end
    @(negedge clkn); #1;
    resetn = 1;
    step(1, 24'h00FF00, 0, 0);
    for (int i = 0; i < LEN + 2; i++) begin
      step(0, '0, 1, 0);
      n_checks++;
      if (obs !== expv) begin
        n_errors++;
        $display("FAIL reset_midcell replay px%0d: got %h want %h", i, obs, expv);
      end
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_back_to_back();
    step(1, 24'($urandom), 0, 0);
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < LEN + 1; i++) begin
        step((i == 0 && c < 99), 24'($urandom), 1, 0);
        n_checks++;
        if (obs !== expv) begin
          n_errors++;
          $display("FAIL back_to_back cell%0d px%0d: got %h want %h", c, i, obs, expv);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || q.size() != 0) begin
      n_errors++;
      $display("FAIL back_to_back flags: got ovf=%b udf=%b want 0 0", overflow, underflow);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clkn); #1;
    test_single_cell();
    test_gaps();
    test_underflow();
    test_overflow();
    test_reset_midcell();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
